// File: rtl/sub_div_pkg.sv
// Shared types and sizes for the iterative restoring divider.
package sub_div_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} sub_div_state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned OP_CNT_W      = 16;

endpackage

// File: rtl/sub_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module sub_div_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] new_rem,
    output logic             q_bit
);

    // Trial value is one bit wider so the shifted-out remainder MSB is kept.
    logic [WIDTH:0] trial;

    always_comb begin
        trial   = {rem, next_bit};
        q_bit   = 1'b0;
        new_rem = rem;
        if (trial >= {1'b0, divisor}) begin
            q_bit   = 1'b1;
            new_rem = WIDTH'(trial - {1'b0, divisor});
        end else begin
            new_rem = WIDTH'(trial);
        end
    end

endmodule

// File: rtl/sub_div_unit.sv
// Iterative unsigned divider, one quotient bit per clock, valid/ready on both sides.
// Optional completed-operation counter enabled by SUB_DIV_PERF_CNT_EN.
module sub_div_unit
    import sub_div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
`ifdef SUB_DIV_PERF_CNT_EN
    ,
    output logic [OP_CNT_W-1:0] op_count
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    sub_div_state_t   state;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-2:0] quo_q;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    sub_div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .next_bit (dvd_q[WIDTH-1]),
        .divisor  (dvs_q),
        .new_rem  (step_rem),
        .q_bit    (step_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef SUB_DIV_PERF_CNT_EN
            op_count    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        dvd_q    <= dividend;
                        dvs_q    <= divisor;
                        rem_q    <= '0;
                        quo_q    <= '0;
                        bit_cnt  <= CNT_W'(WIDTH - 1);
                        in_ready <= 1'b0;
                        // A zero divisor skips iteration and reports immediately.
                        if (divisor == '0) begin
                            state       <= DONE;
                            out_valid   <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q   <= step_rem;
                    quo_q   <= (WIDTH-1)'({quo_q, step_q});
                    dvd_q   <= {dvd_q[WIDTH-2:0], 1'b0};
                    bit_cnt <= bit_cnt - CNT_W'(1);
                    if (bit_cnt == '0) begin
                        state       <= DONE;
                        out_valid   <= 1'b1;
                        quotient    <= {quo_q, step_q};
                        remainder   <= step_rem;
                        div_by_zero <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
`ifdef SUB_DIV_PERF_CNT_EN
                        op_count  <= op_count + OP_CNT_W'(1);
`endif
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_div_unit.sv
// Directed self-checking bench for sub_div_unit (WIDTH=8), table vectors plus corner sequences.
`timescale 1ns/1ps
module tb_sub_div_unit;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
`ifdef SUB_DIV_PERF_CNT_EN
    logic [15:0]  op_count;
`endif

    int checks = 0;
    int errors = 0;

    sub_div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
`ifdef SUB_DIV_PERF_CNT_EN
        ,
        .op_count    (op_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] dvd;
        logic [W-1:0] dvs;
        logic [W-1:0] exp_q;
        logic [W-1:0] exp_r;
        logic         exp_dbz;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Full operation with out_ready held high; checks latency, result and return to idle.
    task automatic run_op(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
        int lat;
        @(negedge clk);
        check("in_ready_before", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        dividend  = dvd;
        divisor   = dvs;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("in_ready_busy", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), (dvs == '0) ? 32'd0 : 32'(W));
        check("quotient", 32'(quotient), 32'(eq));
        check("remainder", 32'(remainder), 32'(er));
        check("div_by_zero", 32'(div_by_zero), 32'(edbz));
        @(posedge clk);
        #1;
        check("out_valid_drop", 32'(out_valid), 32'd0);
        check("in_ready_back", 32'(in_ready), 32'd1);
    endtask

    vec_t vecs [10];

    initial begin
        vecs[0] = '{dvd: 8'd200, dvs: 8'd7,   exp_q: 8'd28,  exp_r: 8'd4,   exp_dbz: 1'b0};
        vecs[1] = '{dvd: 8'd5,   dvs: 8'd0,   exp_q: 8'd255, exp_r: 8'd5,   exp_dbz: 1'b1};
        vecs[2] = '{dvd: 8'd255, dvs: 8'd1,   exp_q: 8'd255, exp_r: 8'd0,   exp_dbz: 1'b0};
        vecs[3] = '{dvd: 8'd3,   dvs: 8'd10,  exp_q: 8'd0,   exp_r: 8'd3,   exp_dbz: 1'b0};
        vecs[4] = '{dvd: 8'd255, dvs: 8'd255, exp_q: 8'd1,   exp_r: 8'd0,   exp_dbz: 1'b0};
        vecs[5] = '{dvd: 8'd100, dvs: 8'd9,   exp_q: 8'd11,  exp_r: 8'd1,   exp_dbz: 1'b0};
        vecs[6] = '{dvd: 8'd0,   dvs: 8'd3,   exp_q: 8'd0,   exp_r: 8'd0,   exp_dbz: 1'b0};
        vecs[7] = '{dvd: 8'd128, dvs: 8'd2,   exp_q: 8'd64,  exp_r: 8'd0,   exp_dbz: 1'b0};
        vecs[8] = '{dvd: 8'd0,   dvs: 8'd0,   exp_q: 8'd255, exp_r: 8'd0,   exp_dbz: 1'b1};
        vecs[9] = '{dvd: 8'd254, dvs: 8'd128, exp_q: 8'd1,   exp_r: 8'd126, exp_dbz: 1'b0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
`ifdef SUB_DIV_PERF_CNT_EN
        check("rst_op_count", 32'(op_count), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].dvd, vecs[i].dvs, vecs[i].exp_q, vecs[i].exp_r, vecs[i].exp_dbz);

        // Backpressure: result held, new requests ignored while out_ready is low.
        @(negedge clk);
        in_valid = 1'b1; dividend = 8'd100; divisor = 8'd9; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (W) @(posedge clk);
        #1;
        check("bp_valid_rise", 32'(out_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1; dividend = 8'd1; divisor = 8'd1;
            @(posedge clk);
            #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_quotient", 32'(quotient), 32'd11);
            check("bp_remainder", 32'(remainder), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);

        // Reset in the middle of an iteration aborts it.
        @(negedge clk);
        in_valid = 1'b1; dividend = 8'd200; divisor = 8'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_quotient", 32'(quotient), 32'd0);
        check("mid_rst_remainder", 32'(remainder), 32'd0);
        check("mid_rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (W + 2) begin
            @(posedge clk);
            #1;
            check("mid_rst_no_result", 32'(out_valid), 32'd0);
        end
        run_op(8'd50, 8'd6, 8'd8, 8'd2, 1'b0);

`ifdef SUB_DIV_PERF_CNT_EN
        run_op(8'd9, 8'd0, 8'd255, 8'd9, 1'b1);
        run_op(8'd9, 8'd3, 8'd3, 8'd0, 1'b0);
        check("op_count_three", 32'(op_count), 32'd3);
        @(negedge clk);
        force dut.op_count = 16'hFFFF;
        #1;
        release dut.op_count;
        run_op(8'd7, 8'd2, 8'd3, 8'd1, 1'b0);
        check("op_count_wrap", 32'(op_count), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
